// File: rtl/fpu_mul_arbiter.sv
// fpu_mul_arbiter: round-robin sharing of one fixed-latency FP32 multiplier between two requesters.
// Sticky exception status exists only when FPU_ARB_STICKY_FLAGS_EN is defined.
module fpu_mul_arbiter #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_result,
    input  logic        mul_invalid,
    input  logic        mul_overflow,
    input  logic        mul_zero,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_result,
    output logic [2:0]  rsp0_flags,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_result,
    output logic [2:0]  rsp1_flags,
    output logic [2:0]  sticky0,
    output logic [2:0]  sticky1,
    input  logic [1:0]  sticky_clr,
    output logic        busy
);

    logic               r_ptr;
    logic [MUL_LAT-1:0] r_tag_v;
    logic [MUL_LAT-1:0] r_tag_id;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_last_v;
    logic               w_last_id;
    logic [2:0]         w_flags;

    // Grants are suppressed during reset so the outputs are quiet from the first reset edge.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!rst && !hold) begin
            if (req0_valid && (!req1_valid || !r_ptr)) begin
                w_grant0 = 1'b1;
            end else if (req1_valid) begin
                w_grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign mul_start  = w_grant0 | w_grant1;
    assign mul_a      = w_grant0 ? req0_a : (w_grant1 ? req1_a : 32'd0);
    assign mul_b      = w_grant0 ? req0_b : (w_grant1 ? req1_b : 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (mul_start) begin
            r_ptr <= w_grant0;
        end
    end

    // Tag pipeline mirrors the multiplier latency so the id lines up with mul_result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_tag_v[0]  <= mul_start;
            r_tag_id[0] <= w_grant1;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    assign w_last_v  = r_tag_v[MUL_LAT-1];
    assign w_last_id = r_tag_id[MUL_LAT-1];
    assign w_flags   = {mul_invalid, mul_overflow, mul_zero};
    assign busy      = |r_tag_v;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp
            logic        r_valid;
            logic [31:0] r_result;
            logic [2:0]  r_flags;
            logic        w_hit;

            assign w_hit = w_last_v && (w_last_id == 1'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid  <= 1'b0;
                    r_result <= 32'd0;
                    r_flags  <= 3'd0;
                end else begin
                    r_valid <= w_hit;
                    if (w_hit) begin
                        r_result <= mul_result;
                        r_flags  <= w_flags;
                    end
                end
            end

`ifdef FPU_ARB_STICKY_FLAGS_EN
            logic [2:0] r_sticky;

            // A response landing together with a clear replaces the status with the new flags.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sticky <= 3'd0;
                end else if (r_valid) begin
                    r_sticky <= sticky_clr[gi] ? r_flags : (r_sticky | r_flags);
                end else if (sticky_clr[gi]) begin
                    r_sticky <= 3'd0;
                end
            end
`endif
        end
    endgenerate

    assign rsp0_valid  = g_rsp[0].r_valid;
    assign rsp0_result = g_rsp[0].r_result;
    assign rsp0_flags  = g_rsp[0].r_flags;
    assign rsp1_valid  = g_rsp[1].r_valid;
    assign rsp1_result = g_rsp[1].r_result;
    assign rsp1_flags  = g_rsp[1].r_flags;

`ifdef FPU_ARB_STICKY_FLAGS_EN
    assign sticky0 = g_rsp[0].r_sticky;
    assign sticky1 = g_rsp[1].r_sticky;
`else
    logic w_unused_clr;
    assign w_unused_clr = ^sticky_clr;
    assign sticky0      = 3'd0;
    assign sticky1      = 3'd0;
`endif

endmodule
